uart_tx_param: RTL and testbench

Parametrised UART transmitter that serialises one `DATA_WIDTH`-bit word per request into a standard asynchronous frame: start bit, data LSB-first, optional parity, and 1 or 2 stop bits. It is the next-generation UART TX in the UART subsystem. Bit timing comes from a clock-enable divider on `clk`; no derived clocks are used. It adds a `busy` status and configurable frame format.

---
 rtl/uart_tx_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised asynchronous-serial transmitter. Each accepted request sends
// one frame: a start bit (0), DATA_WIDTH data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). Bit timing comes from a
// clock-enable style counter running on clk. DIV = CLK_FREQ / BAUDRATE,
// truncated, and must be at least 2.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUDRATE    line rate in bit/s
//   DATA_WIDTH  data bits per frame (5..9)
//   PARITY_EN   1 inserts a parity bit after the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity (only when PARITY_EN = 1)
//   STOP_BITS   1 or 2
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   newd     in   transmit request, sampled only while idle
//   din      in   word to send, captured on the accepting edge
//   tx       out  registered serial line, idle high
//   busy     out  high while a frame is in progress
//   done_tx  out  one-cycle pulse on the edge that ends a frame
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  newd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  tx,
  output logic                  busy,
  output logic                  done_tx
);

  localparam int DIV   = CLK_FREQ / BAUDRATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Control state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [IDX_W-1:0] idx_q,   idx_d;

  // Frame payload (no reset: only read after an accept has loaded it)
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q,   par_d;

  // Registered outputs
  logic tx_q,   tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic bit_end;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ logic'(PARITY_ODD != 0);
  endfunction

  // The last cycle of the current bit period.
  assign bit_end = (baud_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    // The baud counter free-runs inside a frame and wraps at each bit end.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        if (newd) begin
          state_d = S_START;
          shreg_d = din;
          par_d   = parity_bit(din);
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          // Shifting right presents the next data bit at position 0.
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered outputs
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);

    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done_tx = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
// Testbench for uart_tx_param. Four instances share one clock:
//   u0: 8 data bits, no parity, 1 stop
//   u1: 8 data bits, even parity, 1 stop
//   u2: 8 data bits, odd parity, 1 stop
//   u3: 5 data bits, no parity, 2 stop
// All run at DIV = 10. Expected waveforms come from a frame model that lists
// the bits of a frame and holds each for DIV cycles.
module tb_uart_tx_param;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v;
  logic [3:0] newd_v;
  logic [7:0] din0, din1, din2;
  logic [4:0] din3;
  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;
  logic [3:0] tx_v, busy_v, done_v;

  assign tx_v   = {tx3, tx2, tx1, tx0};
  assign busy_v = {busy3, busy2, busy1, busy0};
  assign done_v = {done3, done2, done1, done0};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Results captured by check_frame for scenario-specific checks.
  int obs_bits [16];
  int obs_busy_cycles;
  int obs_low_cycles;
  int obs_high_cycles;
  int frame_start_cyc;
  int last_done_cyc;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_WIDTH(8),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst_v[0]), .newd(newd_v[0]), .din(din0),
    .tx(tx0), .busy(busy0), .done_tx(done0));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_WIDTH(8),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(rst_v[1]), .newd(newd_v[1]), .din(din1),
    .tx(tx1), .busy(busy1), .done_tx(done1));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_WIDTH(8),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(rst_v[2]), .newd(newd_v[2]), .din(din2),
    .tx(tx2), .busy(busy2), .done_tx(done2));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_WIDTH(5),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(rst_v[3]), .newd(newd_v[3]), .din(din3),
    .tx(tx3), .busy(busy3), .done_tx(done3));

  // ---- configuration of each instance --------------------------------------
  function automatic int cfg_w(input int d);
    return (d == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_pe(input int d);
    return (d == 1 || d == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_po(input int d);
    return (d == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // ---- reference model ------------------------------------------------------
  function automatic int frame_bits(input int d);
    return 1 + cfg_w(d) + cfg_pe(d) + cfg_sb(d);
  endfunction

  // Value of frame bit n (0 = start bit).
  function automatic int exp_bit(input int d, input logic [8:0] data, input int n);
    int w;
    int ones;
    logic [8:0] masked;
    w = cfg_w(d);
    masked = data & ((9'd1 << w) - 9'd1);
    if (n == 0) return 0;
    if (n <= w) return int'(masked[n-1]);
    if (cfg_pe(d) == 1 && n == w + 1) begin
      ones = $countones(masked);
      return (ones % 2) ^ cfg_po(d);
    end
    return 1;
  endfunction

  // ---- stimulus helpers ----------------------------------------------------
  task automatic set_din(input int d, input logic [8:0] v);
    case (d)
      0: din0 = v[7:0];
      1: din1 = v[7:0];
      2: din2 = v[7:0];
      default: din3 = v[4:0];
    endcase
  endtask

  // Raise newd away from an edge; return 1 ns after the accepting edge.
  task automatic start_frame(input int d, input logic [8:0] data, input bit hold);
    set_din(d, data);
    newd_v[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) newd_v[d] = 1'b0;
  endtask

  // Called 1 ns after the accepting edge k. Samples tx/busy/done after each
  // edge k..k+F and returns at the sample after edge k+F.
  task automatic check_frame(input int d, input logic [8:0] data, input int inject_t,
                             input bit toggle, input string name);
    int f, ebit, tx_err, busy_err, done_err, first_t, first_got, first_want;
    f = DIV * frame_bits(d);
    tx_err = 0; busy_err = 0; done_err = 0;
    first_t = -1; first_got = 0; first_want = 0;
    obs_busy_cycles = 0; obs_low_cycles = 0; obs_high_cycles = 0;
    frame_start_cyc = cyc;
    for (int i = 0; i < 16; i++) obs_bits[i] = -1;
    for (int t = 0; t < f; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      ebit = exp_bit(d, data, t / DIV);
      if (int'(tx_v[d]) != ebit) begin
        if (first_t < 0) begin
          first_t = t; first_got = int'(tx_v[d]); first_want = ebit;
        end
        tx_err++;
      end
      if (tx_v[d] === 1'b0) obs_low_cycles++;
      if (tx_v[d] === 1'b1) obs_high_cycles++;
      if (t % DIV == DIV / 2) obs_bits[t / DIV] = int'(tx_v[d]);
      if (busy_v[d] === 1'b1) obs_busy_cycles++;
      else busy_err++;
      if (done_v[d] !== 1'b0) done_err++;
      if (toggle) set_din(d, 9'($urandom));
      if (t == inject_t - 1) begin
        set_din(d, 9'h03C);
        newd_v[d] = 1'b1;
      end
      if (t == inject_t) newd_v[d] = 1'b0;
    end
    checks++;
    if (tx_err != 0) begin
      failures++;
      $display("FAIL %s tx: %0d wrong cycles, first at cycle %0d got %0d want %0d",
               name, tx_err, first_t, first_got, first_want);
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL %s busy: low in %0d cycles of frame, want 0", name, busy_err);
    end
    checks++;
    if (done_err != 0) begin
      failures++;
      $display("FAIL %s done_early: done_tx high in %0d frame cycles, want 0", name, done_err);
    end
    @(posedge clk);
    #1;
    last_done_cyc = cyc;
    checks++;
    if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || tx_v[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s end: done=%b busy=%b tx=%b want done=1 busy=0 tx=1",
               name, done_v[d], busy_v[d], tx_v[d]);
    end
  endtask

  // ---- scenarios -----------------------------------------------------------
  task automatic test_reset();
    rst_v  = 4'hF;
    newd_v = 4'h0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    #1;
    checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
      failures++;
      $display("FAIL reset_async: tx=%b busy=%b done=%b want tx=1111 busy=0000 done=0000",
               tx_v, busy_v, done_v);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
      failures++;
      $display("FAIL reset_held: tx=%b busy=%b done=%b want tx=1111 busy=0000 done=0000",
               tx_v, busy_v, done_v);
    end
    @(negedge clk);
    rst_v = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0) begin
      failures++;
      $display("FAIL reset_idle: tx=%b busy=%b want tx=1111 busy=0000", tx_v, busy_v);
    end
  endtask

  task automatic test_basic();
    int want [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int bad;
    start_frame(0, 9'h0A5, 1'b0);
    check_frame(0, 9'h0A5, -1, 1'b0, "basic");
    bad = 0;
    for (int i = 0; i < 10; i++) if (obs_bits[i] != want[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL basic_bits: %0d bits differ, got %0d%0d%0d%0d%0d%0d%0d%0d%0d%0d want 0101001011",
               bad, obs_bits[0], obs_bits[1], obs_bits[2], obs_bits[3], obs_bits[4],
               obs_bits[5], obs_bits[6], obs_bits[7], obs_bits[8], obs_bits[9]);
    end
    checks++;
    if (last_done_cyc - frame_start_cyc != 100 || obs_busy_cycles != 100) begin
      failures++;
      $display("FAIL basic_timing: done at k+%0d busy %0d cycles, want k+100 and 100",
               last_done_cyc - frame_start_cyc, obs_busy_cycles);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done0 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width: done_tx=%b one cycle after pulse, want 0", done0);
    end
  endtask

  task automatic test_parity();
    start_frame(1, 9'h007, 1'b0);
    check_frame(1, 9'h007, -1, 1'b0, "parity_even_07");
    checks++;
    if (obs_bits[9] != 1 || obs_busy_cycles != 110) begin
      failures++;
      $display("FAIL parity_even_07: parity=%0d busy=%0d want parity=1 busy=110",
               obs_bits[9], obs_busy_cycles);
    end
    start_frame(2, 9'h007, 1'b0);
    check_frame(2, 9'h007, -1, 1'b0, "parity_odd_07");
    checks++;
    if (obs_bits[9] != 0 || obs_busy_cycles != 110) begin
      failures++;
      $display("FAIL parity_odd_07: parity=%0d busy=%0d want parity=0 busy=110",
               obs_bits[9], obs_busy_cycles);
    end
    start_frame(1, 9'h000, 1'b0);
    check_frame(1, 9'h000, -1, 1'b0, "parity_even_00");
    checks++;
    if (obs_bits[9] != 0) begin
      failures++;
      $display("FAIL parity_even_00: parity=%0d want 0", obs_bits[9]);
    end
  endtask

  task automatic test_format();
    start_frame(3, 9'h01F, 1'b0);
    check_frame(3, 9'h01F, -1, 1'b0, "format_w5_2stop");
    checks++;
    if (obs_low_cycles != 10 || obs_high_cycles != 70 ||
        last_done_cyc - frame_start_cyc != 80) begin
      failures++;
      $display("FAIL format_shape: low=%0d high=%0d done at k+%0d want 10, 70, k+80",
               obs_low_cycles, obs_high_cycles, last_done_cyc - frame_start_cyc);
    end
  endtask

  task automatic test_ignored_request();
    int bad;
    start_frame(0, 9'h0C3, 1'b0);
    check_frame(0, 9'h0C3, 40, 1'b1, "ignored");
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ignored_no_second_frame: %0d busy/low cycles after frame, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    start_frame(0, 9'h000, 1'b0);
    repeat (35) @(posedge clk);
    #3;
    checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: tx=%b busy=%b want tx=0 busy=1", tx0, busy0);
    end
    rst_v[0] = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: tx=%b busy=%b want tx=1 busy=0", tx0, busy0);
    end
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done0 !== 1'b0) bad++;
    end
    @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy/low, want 0", bad);
    end
    start_frame(0, 9'h081, 1'b0);
    check_frame(0, 9'h081, -1, 1'b0, "after_reset_81");
  endtask

  task automatic test_back_to_back();
    int d1;
    start_frame(0, 9'h055, 1'b1);
    set_din(0, 9'h0AA);
    check_frame(0, 9'h055, -1, 1'b0, "b2b_first");
    d1 = last_done_cyc;
    @(posedge clk);
    #1;
    newd_v[0] = 1'b0;
    checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: tx=%b busy=%b done=%b want tx=0 busy=1 done=0",
               tx0, busy0, done0);
    end
    check_frame(0, 9'h0AA, -1, 1'b0, "b2b_second");
    checks++;
    if (last_done_cyc - d1 != 101) begin
      failures++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, want 101", last_done_cyc - d1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop: busy=%b done=%b want busy=0 done=0", busy0, done0);
    end
  endtask

  task automatic test_random();
    int d;
    logic [8:0] data;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 3));
      data = 9'($urandom);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      start_frame(d, data, 1'b0);
      check_frame(d, data, -1, 1'b0, $sformatf("random%0d_u%0d", i, d));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_format();
    test_ignored_request();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
